// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: o_diff = i_x - i_y - i_borrow, one bit per clock,
// LSB first. One full-subtractor cell, a borrow flop and shift registers, behind a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_borrow,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-subtractor cell working on the current LSBs and the stored borrow.
  logic x_bit, y_bit, d_bit, f_next;

  always_comb begin
    x_bit  = x_q[0];
    y_bit  = y_q[0];
    d_bit  = x_bit ^ y_bit ^ f_q;
    f_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & f_q);
  end

  // NOTE: every signal assigned in this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    logic accept;
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    f_d      = f_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    accept   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) accept = 1'b1;
      end
      S_RUN: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        f_d   = f_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          diff_d   = res_d;
          borrow_d = f_next;
          cnt_d    = '0;
        end
      end
      S_DONE: begin
        if (i_start) accept = 1'b1;
        else         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Start is honoured only from IDLE or DONE; RUN never looks at it.
    if (accept) begin
      state_d = S_RUN;
      x_d     = i_x;
      y_d     = i_y;
      f_d     = i_borrow;
      res_d   = '0;
      cnt_d   = '0;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      f_q      <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      res_q    <= res_d;
      f_q      <= f_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table and handshake corner
// cases at WIDTH=8, plus randomized sweeps at WIDTH=1, 8 and 32 against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s1, x1, y1, b1, busy1, done1, bo1;
  logic [0:0]  diff1;
  logic        s8, b8, busy8, done8, bo8;
  logic [7:0]  x8, y8, diff8;
  logic        s32, b32, busy32, done32, bo32;
  logic [31:0] x32, y32, diff32;

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_start(s1), .i_x(x1), .i_y(y1), .i_borrow(b1),
    .o_busy(busy1), .o_done(done1), .o_diff(diff1), .o_borrow(bo1)
  );
  serial_subtractor #(.WIDTH(8)) u_w8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_x(x8), .i_y(y8), .i_borrow(b8),
    .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_borrow(bo8)
  );
  serial_subtractor #(.WIDTH(32)) u_w32 (
    .i_clk(clk), .i_rst(rst), .i_start(s32), .i_x(x32), .i_y(y32), .i_borrow(b32),
    .o_busy(busy32), .o_done(done32), .o_diff(diff32), .o_borrow(bo32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic; returns {borrow, diff} with diff masked to w bits.
  function automatic logic [32:0] ref_sub(input longint unsigned x, input longint unsigned y,
                                          input longint unsigned b, input int w);
    longint unsigned mask, r;
    mask = (64'd1 << w) - 64'd1;
    r    = (x - y - b) & mask;
    return {(x < y + b) ? 1'b1 : 1'b0, r[31:0]};
  endfunction

  // One WIDTH=8 operation: accept, W busy cycles, done exactly W cycles after acceptance.
  task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic b,
                         input logic [7:0] ed, input logic eb, input string name);
    int early;
    early = 0;
    @(negedge clk);
    x8 = x; y8 = y; b8 = b; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); b8 = 1'($urandom);
    check({name, " busy"}, 64'(busy8), 64'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c < 8 && done8) early++;
    end
    check({name, " done/borrow/diff"}, 64'({done8, bo8, diff8}), 64'({1'b1, eb, ed}));
    check({name, " early done"}, 64'(early), 64'd0);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       b;
    logic [7:0] diff;
    logic       bo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dcount, stray;
    logic [32:0] e1, e8, e32;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1};

    rst = 1'b1;
    s1 = 0; x1 = 0; y1 = 0; b1 = 0;
    s8 = 0; x8 = 0; y8 = 0; b8 = 0;
    s32 = 0; x32 = 0; y32 = 0; b32 = 0;
    #12;
    check("reset w8", 64'({busy8, done8, bo8, diff8}), 64'd0);
    check("reset w1", 64'({busy1, done1, bo1, diff1}), 64'd0);
    check("reset w32", 64'({busy32, done32, bo32, diff32}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 8; i++)
      run_op8(vecs[i].x, vecs[i].y, vecs[i].b, vecs[i].diff, vecs[i].bo, $sformatf("vec%0d", i));

    // Start pulse during RUN must be ignored
    dcount = 0;
    @(negedge clk);
    x8 = 8'h80; y8 = 8'h01; b8 = 1'b0; s8 = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (done8) dcount++;
      if (c == 0) s8 = 1'b0;
      if (c == 2) begin s8 = 1'b1; x8 = 8'hFF; end
      if (c == 3) s8 = 1'b0;
      if (c == 8) check("ignore_start result", 64'({done8, bo8, diff8}), 64'({1'b1, 1'b0, 8'h7F}));
      if (c == 9) check("ignore_start no restart", 64'(busy8), 64'd0);
    end
    check("ignore_start single done", 64'(dcount), 64'd1);

    // Reset in the middle of RUN aborts the operation
    @(negedge clk);
    x8 = 8'h55; y8 = 8'h11; b8 = 1'b0; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    check("abort busy before reset", 64'(busy8), 64'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort outputs cleared", 64'({busy8, done8, bo8, diff8}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8 || busy8) dcount++;
    end
    check("abort no done", 64'(dcount), 64'd0);
    run_op8(8'h55, 8'h11, 1'b0, 8'h44, 1'b0, "post_reset");

    // Back-to-back: start held through DONE
    @(negedge clk);
    x8 = 8'h05; y8 = 8'h03; b8 = 1'b0; s8 = 1'b1;
    @(negedge clk);
    x8 = 8'h10; y8 = 8'h10;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 8) check("b2b first", 64'({done8, bo8, diff8}), 64'({1'b1, 1'b0, 8'h02}));
      if (c == 9) begin
        check("b2b no idle", 64'({busy8, done8, diff8}), 64'({1'b1, 1'b0, 8'h02}));
        s8 = 1'b0;
      end
      if (c == 13) check("b2b held", 64'({busy8, bo8, diff8}), 64'({1'b1, 1'b0, 8'h02}));
      if (c == 17) check("b2b second", 64'({done8, bo8, diff8}), 64'({1'b1, 1'b0, 8'h00}));
    end
    @(negedge clk);

    // Randomized sweep, all widths in lockstep; first 8 ops cover WIDTH=1 exhaustively
    stray = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i < 8) begin
        x1 = 1'(i >> 2); y1 = 1'(i >> 1); b1 = 1'(i);
      end else begin
        x1 = 1'($urandom); y1 = 1'($urandom); b1 = 1'($urandom);
      end
      x8 = 8'($urandom); y8 = 8'($urandom); b8 = 1'($urandom);
      x32 = $urandom; y32 = $urandom; b32 = 1'($urandom);
      if (i % 16 == 1) x32 = y32;
      if (i % 16 == 2) begin x32 = 32'hFFFF_FFFF; y32 = 32'hFFFF_FFFF; b32 = 1'b1; end
      e1  = ref_sub(64'(x1), 64'(y1), 64'(b1), 1);
      e8  = ref_sub(64'(x8), 64'(y8), 64'(b8), 8);
      e32 = ref_sub(64'(x32), 64'(y32), 64'(b32), 32);
      s1 = 1'b1; s8 = 1'b1; s32 = 1'b1;
      @(negedge clk);
      s1 = 1'b0; s8 = 1'b0; s32 = 1'b0;
      x1 = 1'($urandom); x8 = 8'($urandom); x32 = $urandom;
      check($sformatf("rnd%0d busy", i), 64'({busy1, busy8, busy32}), 64'(3'b111));
      for (int c = 1; c <= 33; c++) begin
        @(negedge clk);
        if (c == 1)
          check($sformatf("rnd%0d w1", i), 64'({done1, bo1, diff1}), 64'({1'b1, e1[32], e1[0]}));
        else if (done1) stray++;
        if (c == 8)
          check($sformatf("rnd%0d w8", i), 64'({done8, bo8, diff8}), 64'({1'b1, e8[32], e8[7:0]}));
        else if (done8) stray++;
        if (c == 32)
          check($sformatf("rnd%0d w32", i), 64'({done32, bo32, diff32}), 64'({1'b1, e32[32], e32[31:0]}));
        else if (done32) stray++;
      end
    end
    check("random stray done pulses", 64'(stray), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
